// File: rtl/io_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler and level compare interrupt.
// Latency: writes land at the io_en edge; read data is registered, valid 1 cycle after io_en.
// Backpressure: none; every access completes in its own cycle with no wait states.
module io_timer #(
  parameter logic [7:0]  BASE_ADDR      = 8'hE0,
  parameter logic [31:0] PRESCALE_RESET = 32'd0,
  parameter logic        ENABLE_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        irq_mtimecmp
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        enable_q, enable_d;
  logic [31:0] prescale_q, prescale_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic       sel;
  logic       wr;
  logic       rd;
  logic [2:0] off;
  logic       tick;

  // Decode, prescaler, register writes, read mux and compare for the next edge
  always_comb begin
    sel = io_en && (io_addr[7:5] == BASE_ADDR[7:5]) && (io_addr[1:0] == 2'b00);
    off = io_addr[4:2];
    wr  = sel && io_we;
    rd  = sel && !io_we;

    tick = enable_q && (cnt_q == 32'd0);

    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    rdata_d    = rdata_q;

    // Counter only moves while enabled; reaching zero produces the tick and reloads
    if (enable_q) begin
      cnt_d = tick ? prescale_q : cnt_q - 32'd1;
    end

    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A write to either mtime half replaces any increment this cycle
    if (wr) begin
      case (off)
        OFF_MTIME_LO: mtime_d = {mtime_q[63:32], io_data_write};
        OFF_MTIME_HI: mtime_d = {io_data_write, mtime_q[31:0]};
        OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], io_data_write};
        OFF_CMP_HI:   mtimecmp_d = {io_data_write, mtimecmp_q[31:0]};
        OFF_CTRL:     enable_d = io_data_write[0];
        OFF_PRESCALE: begin
          prescale_d = io_data_write;
          cnt_d      = io_data_write;
        end
        default: ;
      endcase
    end

    // Reading mtime_lo freezes the high half so a lo-then-hi pair is coherent
    if (rd) begin
      case (off)
        OFF_MTIME_LO: begin
          rdata_d = mtime_q[31:0];
          snap_d  = mtime_q[63:32];
        end
        OFF_MTIME_HI: rdata_d = snap_q;
        OFF_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        OFF_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        OFF_CTRL:     rdata_d = {31'd0, enable_q};
        OFF_PRESCALE: rdata_d = prescale_q;
        default:      rdata_d = 32'd0;
      endcase
    end

    irq_d = (mtime_q >= mtimecmp_q);
  end

  // State registers; reset wins over any access or tick in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable_q   <= ENABLE_RESET;
      prescale_q <= PRESCALE_RESET;
      cnt_q      <= PRESCALE_RESET;
      snap_q     <= 32'd0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      enable_q   <= enable_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign io_data_read = rdata_q;
  assign irq_mtimecmp = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: directed sequences, a register vector table and randomized traffic,
// all checked against a cycle-level reference of the timer's documented behaviour.
// Outputs are sampled on the falling edge.
module tb_io_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic        irq_mtimecmp;

  always #5 clk = ~clk;

  io_timer dut (
    .clk(clk),
    .reset(reset),
    .io_addr(io_addr),
    .io_en(io_en),
    .io_we(io_we),
    .io_data_write(io_data_write),
    .io_data_read(io_data_read),
    .irq_mtimecmp(irq_mtimecmp)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: the time value, compare value, and prescaler as "enabled clocks since last tick"
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [31:0] m_pre;
  logic [31:0] m_elapsed;
  logic [31:0] m_snap;
  logic [31:0] m_rd;
  logic        m_irq;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one edge of the timer's documented rules to the reference state
  task automatic model_edge(input logic rst, input logic en, input logic we,
                            input logic [7:0] a, input logic [31:0] d);
    logic        sel;
    logic [2:0]  off;
    logic        tick;
    logic [63:0] t_old;
    logic [63:0] c_old;
    logic        en_old;
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_en = 1'b1; m_pre = 32'd0;
      m_elapsed = 32'd0; m_snap = 32'd0; m_rd = 32'd0; m_irq = 1'b0;
      return;
    end
    t_old  = m_mtime;
    c_old  = m_cmp;
    en_old = m_en;
    sel  = en && (a[7:5] == 3'b111) && (a[1:0] == 2'b00);
    off  = a[4:2];
    tick = m_en && (m_elapsed == m_pre);
    if (m_en) m_elapsed = tick ? 32'd0 : m_elapsed + 32'd1;
    if (tick) m_mtime = t_old + 64'd1;
    if (sel && we) begin
      case (off)
        3'd0: m_mtime = {t_old[63:32], d};
        3'd1: m_mtime = {d, t_old[31:0]};
        3'd2: m_cmp[31:0] = d;
        3'd3: m_cmp[63:32] = d;
        3'd4: m_en = d[0];
        3'd5: begin m_pre = d; m_elapsed = 32'd0; end
        default: ;
      endcase
    end
    if (sel && !we) begin
      case (off)
        3'd0: begin m_rd = t_old[31:0]; m_snap = t_old[63:32]; end
        3'd1: m_rd = m_snap;
        3'd2: m_rd = c_old[31:0];
        3'd3: m_rd = c_old[63:32];
        3'd4: m_rd = {31'd0, en_old};
        3'd5: m_rd = m_pre;
        default: m_rd = 32'd0;
      endcase
    end
    m_irq = (t_old >= c_old);
  endtask

  // One clock: drive, advance reference at the edge, compare outputs on the falling edge
  task automatic step(input logic rst, input logic en, input logic we,
                      input logic [7:0] a, input logic [31:0] d);
    reset = rst; io_en = en; io_we = we; io_addr = a; io_data_write = d;
    @(posedge clk);
    model_edge(rst, en, we, a, d);
    @(negedge clk);
    reset = 1'b0; io_en = 1'b0; io_we = 1'b0;
    check32("io_data_read", io_data_read, m_rd);
    check32("irq_mtimecmp", {31'd0, irq_mtimecmp}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'd0);
  endtask

  vec_t vecs[$];
  logic [31:0] base_lo;

  initial begin
    reset = 1'b1; io_en = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_data_write = 32'd0;

    // Reset, then 10 idle clocks at prescale 0
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    check32("reset_rdata", io_data_read, 32'd0);
    idle(10);
    rd(8'hE0);
    check32("lo_after_10", io_data_read, 32'd10);
    rd(8'hE4);
    check32("hi_snapshot_zero", io_data_read, 32'd0);
    check32("irq_idle", {31'd0, irq_mtimecmp}, 32'd0);

    // Prescale 3: one tick per four clocks; then freeze with enable=0
    rd(8'hE0);
    base_lo = io_data_read;
    wr(8'hF4, 32'd3);
    idle(40);
    rd(8'hE0);
    check32("prescale3_advance", io_data_read, base_lo + 32'd12);
    wr(8'hF0, 32'd0);
    idle(20);
    rd(8'hE0);
    check32("frozen", io_data_read, base_lo + 32'd12);

    // Interrupt crossing at mtime = 0x1_0000_0000
    wr(8'hF4, 32'd0);
    wr(8'hEC, 32'd1);
    wr(8'hE8, 32'd0);
    wr(8'hE4, 32'd0);
    wr(8'hE0, 32'hFFFF_FFFE);
    wr(8'hF0, 32'd1);
    idle(2);
    check32("irq_not_early", {31'd0, irq_mtimecmp}, 32'd0);
    idle(1);
    check32("irq_rise", {31'd0, irq_mtimecmp}, 32'd1);
    wr(8'hEC, 32'd2);
    check32("irq_hold_on_write_edge", {31'd0, irq_mtimecmp}, 32'd1);
    idle(1);
    check32("irq_drop", {31'd0, irq_mtimecmp}, 32'd0);

    // Atomic lo/hi read straddling a carry
    wr(8'hF0, 32'd0);
    wr(8'hE8, 32'hFFFF_FFFF);
    wr(8'hEC, 32'hFFFF_FFFF);
    wr(8'hE4, 32'd0);
    wr(8'hE0, 32'hFFFF_FFFF);
    wr(8'hF0, 32'd1);
    rd(8'hE0);
    check32("atomic_lo", io_data_read, 32'hFFFF_FFFF);
    rd(8'hE4);
    check32("atomic_hi_snapshot", io_data_read, 32'd0);

    // Write to mtime_lo in a tick cycle drops the increment
    wr(8'hE0, 32'h55);
    rd(8'hE0);
    check32("write_beats_tick", io_data_read, 32'h55);

    // Register vectors with the timer frozen at mtime_lo = 0x57
    wr(8'hF0, 32'd0);
    vecs = '{
      '{8'hE8, 1'b1, 32'hA5A5_0001, 1'b0, 32'd0},
      '{8'hE8, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001},
      '{8'hEC, 1'b1, 32'h0000_1234, 1'b0, 32'd0},
      '{8'hEC, 1'b0, 32'd0,         1'b1, 32'h0000_1234},
      '{8'hF4, 1'b1, 32'd7,         1'b0, 32'd0},
      '{8'hF4, 1'b0, 32'd0,         1'b1, 32'd7},
      '{8'hF0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0},
      '{8'hF0, 1'b0, 32'd0,         1'b1, 32'd0},
      '{8'h60, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0},
      '{8'hE0, 1'b0, 32'd0,         1'b1, 32'h57},
      '{8'hE1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'd0},
      '{8'hE0, 1'b0, 32'd0,         1'b1, 32'h57},
      '{8'hF8, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0},
      '{8'hF8, 1'b0, 32'd0,         1'b1, 32'd0},
      '{8'hFC, 1'b0, 32'd0,         1'b1, 32'd0},
      '{8'hE8, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001},
      '{8'hE1, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001},
      '{8'h60, 1'b0, 32'd0,         1'b1, 32'hA5A5_0001},
      '{8'hE4, 1'b1, 32'd9,         1'b0, 32'd0},
      '{8'hE0, 1'b0, 32'd0,         1'b1, 32'h57},
      '{8'hE4, 1'b0, 32'd0,         1'b1, 32'd9}
    };
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].data);
      if (vecs[i].chk) check32($sformatf("vec%0d", i), io_data_read, vecs[i].exp);
    end

    // Reset mid-count with the interrupt asserted
    wr(8'hF0, 32'd1);
    wr(8'hEC, 32'd0);
    wr(8'hE8, 32'd0);
    idle(5);
    check32("irq_before_reset", {31'd0, irq_mtimecmp}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 8'hE0, 32'h1234_5678);
    check32("reset_irq", {31'd0, irq_mtimecmp}, 32'd0);
    check32("reset_rd", io_data_read, 32'd0);
    rd(8'hE0); check32("reset_mtime_lo", io_data_read, 32'd0);
    rd(8'hE4); check32("reset_mtime_hi", io_data_read, 32'd0);
    rd(8'hE8); check32("reset_cmp_lo", io_data_read, 32'hFFFF_FFFF);
    rd(8'hEC); check32("reset_cmp_hi", io_data_read, 32'hFFFF_FFFF);
    rd(8'hF0); check32("reset_ctrl", io_data_read, 32'd1);
    rd(8'hF4); check32("reset_prescale", io_data_read, 32'd0);

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick < 8)       a = 8'hE0 + 8'(pick * 4);
      else if (pick == 8) a = 8'($urandom);
      else                a = 8'hE0 + 8'($urandom_range(0, 7) * 4) + 8'd1;
      d = $urandom;
      if (a == 8'hF4) d = $urandom_range(0, 6);
      if (a == 8'hF0) d[0] = ($urandom_range(0, 3) != 0);
      if ((a == 8'hE4 || a == 8'hEC) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 1);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
